// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - byte-serial RAM/IO port shared by instruction fetch and load/store buffer
//
// Arbitrates between IF (word reads) and LSB (byte/half/word loads and stores)
// round-robin, serialises each access into single-byte RAM cycles, assembles
// read data little-endian and pulses a one-cycle ok to the winning requester.
//
// Ports:
//   clockIn, resetIn      clock (rising edge), synchronous active-low reset
//   readyIn               global enable, 0 holds every register
//   clearIn               pipeline flush, aborts in-flight reads
//   ifFlag/ifAddr         IF word read request (held until ifOkFlag)
//   ifData/ifOkFlag       fetched word and its completion pulse
//   lsbFlag/lsbOp         LSB request; op[2]=store, op[1:0]=byte/half/word
//   lsbAddr/lsbDataIn     LSB byte address and store data
//   lsbDataOut/lsbOkFlag  zero-extended load data and completion pulse
//   ramIn                 RAM read byte, one cycle after its address
//   ramOut/ramAddr        RAM write byte and byte address
//   ramWrite              RAM write strobe
//   ioBufferFull          IO write buffer full, stalls IO stores

module memory_controller #(
  parameter logic [31:0] IO_ADDR_HI = 32'h0003_0000
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        readyIn,
  input  logic        clearIn,
  input  logic        ifFlag,
  input  logic [31:0] ifAddr,
  output logic [31:0] ifData,
  output logic        ifOkFlag,
  input  logic        lsbFlag,
  input  logic [2:0]  lsbOp,
  input  logic [31:0] lsbAddr,
  input  logic [31:0] lsbDataIn,
  output logic [31:0] lsbDataOut,
  output logic        lsbOkFlag,
  input  logic [7:0]  ramIn,
  output logic [7:0]  ramOut,
  output logic [31:0] ramAddr,
  output logic        ramWrite,
  input  logic        ioBufferFull
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] lsb_data_q, lsb_data_d;
  logic [1:0]  size_q, size_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        is_if_q, is_if_d;
  logic        last_if_q, last_if_d;
  logic        if_ok_q, if_ok_d;
  logic        lsb_ok_q, lsb_ok_d;
  logic        lsb_ok_rd_q, lsb_ok_rd_d;

  logic [2:0]  nbytes;
  logic [31:0] byte_addr;
  logic        io_stall;
  logic        grant_if;
  logic        grant_lsb;

  always_comb begin
    unique case (size_q)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    byte_addr = addr_q + {29'd0, cnt_q};
    io_stall  = (byte_addr >= IO_ADDR_HI) && ioBufferFull;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    if_data_d   = if_data_q;
    lsb_data_d  = lsb_data_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    is_if_d     = is_if_q;
    last_if_d   = last_if_q;
    lsb_ok_rd_d = lsb_ok_rd_q;
    if_ok_d     = 1'b0;
    lsb_ok_d    = 1'b0;
    grant_if    = 1'b0;
    grant_lsb   = 1'b0;
    ramWrite    = 1'b0;
    ramAddr     = 32'd0;
    ramOut      = 8'd0;

    unique case (state_q)
      S_IDLE: begin
        // No grant during an ok cycle: the completed requester still holds its flag.
        if (!clearIn && !if_ok_q && !lsb_ok_q) begin
          grant_if  = ifFlag && (!lsbFlag || !last_if_q);
          grant_lsb = lsbFlag && !grant_if;
          if (grant_if) begin
            addr_d    = ifAddr;
            size_d    = 2'b10;
            is_if_d   = 1'b1;
            last_if_d = 1'b1;
            cnt_d     = 3'd0;
            rdata_d   = 32'd0;
            state_d   = S_READ;
          end else if (grant_lsb) begin
            addr_d    = lsbAddr;
            size_d    = lsbOp[1:0];
            wdata_d   = lsbDataIn;
            is_if_d   = 1'b0;
            last_if_d = 1'b0;
            cnt_d     = 3'd0;
            rdata_d   = 32'd0;
            state_d   = lsbOp[2] ? S_WRITE : S_READ;
          end
        end
      end

      S_READ: begin
        // cnt_q is the byte being addressed; ramIn carries byte cnt_q-1.
        ramAddr = byte_addr;
        case (cnt_q)
          3'd1:    rdata_d[7:0]   = ramIn;
          3'd2:    rdata_d[15:8]  = ramIn;
          3'd3:    rdata_d[23:16] = ramIn;
          3'd4:    rdata_d[31:24] = ramIn;
          default: ;
        endcase
        if (clearIn) begin
          state_d = S_IDLE;
        end else if (cnt_q == nbytes) begin
          state_d = S_IDLE;
          if (is_if_q) begin
            if_ok_d   = 1'b1;
            if_data_d = rdata_d;
          end else begin
            lsb_ok_d    = 1'b1;
            lsb_ok_rd_d = 1'b1;
            lsb_data_d  = rdata_d;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      S_WRITE: begin
        ramAddr = byte_addr;
        case (cnt_q[1:0])
          2'd0:    ramOut = wdata_q[7:0];
          2'd1:    ramOut = wdata_q[15:8];
          2'd2:    ramOut = wdata_q[23:16];
          default: ramOut = wdata_q[31:24];
        endcase
        // Stores are committed, so clearIn is ignored here.
        if (!io_stall) begin
          ramWrite = 1'b1;
          if (cnt_q == nbytes - 3'd1) begin
            state_d     = S_IDLE;
            lsb_ok_d    = 1'b1;
            lsb_ok_rd_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      if_data_q   <= 32'd0;
      lsb_data_q  <= 32'd0;
      size_q      <= 2'd0;
      cnt_q       <= 3'd0;
      is_if_q     <= 1'b0;
      last_if_q   <= 1'b0;
      if_ok_q     <= 1'b0;
      lsb_ok_q    <= 1'b0;
      lsb_ok_rd_q <= 1'b0;
    end else if (readyIn) begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      if_data_q   <= if_data_d;
      lsb_data_q  <= lsb_data_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      is_if_q     <= is_if_d;
      last_if_q   <= last_if_d;
      if_ok_q     <= if_ok_d;
      lsb_ok_q    <= lsb_ok_d;
      lsb_ok_rd_q <= lsb_ok_rd_d;
    end
  end

  // A flush landing on a read's ok cycle still discards it; store oks stand.
  assign ifOkFlag   = if_ok_q & ~clearIn;
  assign lsbOkFlag  = lsb_ok_q & ~(clearIn & lsb_ok_rd_q);
  assign ifData     = if_data_q;
  assign lsbDataOut = lsb_data_q;

endmodule

// File: tb/tb_memory_controller.sv
// tb/tb_memory_controller.sv - scoreboard bench for memory_controller with directed and random traffic

module tb_memory_controller;

  logic        clk = 1'b0;
  logic        resetIn, readyIn, clearIn;
  logic        ifFlag, ifOkFlag, lsbFlag, lsbOkFlag;
  logic [31:0] ifAddr, ifData, lsbAddr, lsbDataIn, lsbDataOut, ramAddr;
  logic [2:0]  lsbOp;
  logic [7:0]  ramIn, ramOut;
  logic        ramWrite, ioBufferFull;

  always #5 clk = ~clk;

  memory_controller #(.IO_ADDR_HI(32'h0003_0000)) dut (
    .clockIn(clk), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn),
    .ifFlag(ifFlag), .ifAddr(ifAddr), .ifData(ifData), .ifOkFlag(ifOkFlag),
    .lsbFlag(lsbFlag), .lsbOp(lsbOp), .lsbAddr(lsbAddr), .lsbDataIn(lsbDataIn),
    .lsbDataOut(lsbDataOut), .lsbOkFlag(lsbOkFlag), .ramIn(ramIn), .ramOut(ramOut),
    .ramAddr(ramAddr), .ramWrite(ramWrite), .ioBufferFull(ioBufferFull)
  );

  logic [7:0] mem     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] pat(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pat(a);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + 32'(i));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
  endtask

  task automatic put(input logic [31:0] a, input logic [7:0] b);
    mem[a] = b;
    ref_mem[a] = b;
  endtask

  // RAM shares the controller's ready gating.
  always @(posedge clk) begin
    if (readyIn) begin
      if (ramWrite) mem[ramAddr] = ramOut;
      ramIn <= mem_rd(ramAddr);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  logic [31:0] exp_if[$];
  logic [32:0] exp_lsb[$];   // [32]=load (data checked), [31:0]=expected load data

  initial begin : monitor
    logic [31:0] e;
    logic [32:0] l;
    forever begin
      @(negedge clk);
      if (ifOkFlag === 1'b1) begin
        n_checks++;
        if (exp_if.size() == 0) begin
          n_fail++;
          $display("FAIL if_ok_unexpected: got ifOkFlag=1 expected no ok");
        end else begin
          e = exp_if.pop_front();
          check("if_data", ifData, e);
        end
      end
      if (lsbOkFlag === 1'b1) begin
        n_checks++;
        if (exp_lsb.size() == 0) begin
          n_fail++;
          $display("FAIL lsb_ok_unexpected: got lsbOkFlag=1 expected no ok");
        end else begin
          l = exp_lsb.pop_front();
          if (l[32]) check("lsb_load_data", lsbDataOut, l[31:0]);
        end
      end
      if (ramWrite === 1'b1) begin
        n_checks++;
        if (ramAddr >= 32'h0003_0000 && ioBufferFull) begin
          n_fail++;
          $display("FAIL io_stall: got write to 0x%08h with ioBufferFull=1 expected no write", ramAddr);
        end
      end
    end
  end

  logic [31:0] rec_addr[32], rec_wr[32], rec_out[32], rec_if_ok[32], rec_lsb_ok[32];
  logic [31:0] rec_ifdata[32], rec_lsbdata[32];

  // Runs a window starting in the current cycle (cycle 0); inputs change 2 time units after each edge.
  task automatic run_window(input int ncyc, input int io_until, input int clear_at,
                            input int rdy_lo, input int rdy_hi, input int rst_at, input int if_keep);
    int if_oks = 0;
    for (int c = 0; c < ncyc; c++) begin
      ioBufferFull = (c < io_until);
      clearIn      = (c == clear_at);
      readyIn      = !(c >= rdy_lo && c <= rdy_hi);
      resetIn      = (c != rst_at);
      @(negedge clk);
      rec_addr[c]    = ramAddr;
      rec_wr[c]      = {31'd0, ramWrite};
      rec_out[c]     = {24'd0, ramOut};
      rec_if_ok[c]   = {31'd0, ifOkFlag};
      rec_lsb_ok[c]  = {31'd0, lsbOkFlag};
      rec_ifdata[c]  = ifData;
      rec_lsbdata[c] = lsbDataOut;
      @(posedge clk); #2;
      if (rec_if_ok[c][0]) begin
        if_oks++;
        if (if_oks > if_keep) ifFlag = 1'b0;
      end
      if (rec_lsb_ok[c][0]) lsbFlag = 1'b0;
      if (c == clear_at) begin
        ifFlag = 1'b0;
        if (!lsbOp[2]) lsbFlag = 1'b0;
      end
      if (c == rst_at) begin
        ifFlag  = 1'b0;
        lsbFlag = 1'b0;
      end
    end
    ioBufferFull = 1'b0;
    clearIn      = 1'b0;
    readyIn      = 1'b1;
    resetIn      = 1'b1;
  endtask

  task automatic if_agent(input int n);
    for (int k = 0; k < n; k++) begin
      int          budget;
      logic [31:0] a;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
      a = 32'h1000 + 32'($urandom_range(0, 255));
      ifAddr = a;
      ifFlag = 1'b1;
      exp_if.push_back(ref_load(a, 4));
      budget = 300;
      do begin @(negedge clk); budget--; end while (ifOkFlag !== 1'b1 && budget > 0);
      if (ifOkFlag !== 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL if_timeout: got no ifOkFlag for 0x%08h expected ok within 300 cycles", a);
      end
      @(posedge clk); #2;
      ifFlag = 1'b0;
    end
  endtask

  task automatic lsb_agent(input int n);
    for (int k = 0; k < n; k++) begin
      int          budget, nb, region;
      logic [1:0]  sz;
      logic        st;
      logic [31:0] a, d;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
      st     = 1'($urandom_range(0, 1));
      sz     = 2'($urandom_range(0, 2));
      nb     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      region = $urandom_range(0, 2);
      a = (region == 0) ? 32'($urandom_range(0, 63)) :
          (region == 1) ? 32'h0003_0000 + 32'($urandom_range(0, 7)) :
                          32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      d = $urandom;
      lsbAddr   = a;
      lsbDataIn = d;
      lsbOp     = {st, sz};
      if (st) begin
        ref_store(a, nb, d);
        exp_lsb.push_back({1'b0, 32'd0});
      end else begin
        exp_lsb.push_back({1'b1, ref_load(a, nb)});
      end
      lsbFlag = 1'b1;
      budget = 300;
      do begin @(negedge clk); budget--; end while (lsbOkFlag !== 1'b1 && budget > 0);
      if (lsbOkFlag !== 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL lsb_timeout: got no lsbOkFlag for 0x%08h expected ok within 300 cycles", a);
      end
      @(posedge clk); #2;
      lsbFlag = 1'b0;
    end
  endtask

  bit rand_done = 1'b0;

  initial begin
    resetIn = 1'b0; readyIn = 1'b1; clearIn = 1'b0; ioBufferFull = 1'b0;
    ifFlag = 1'b0; ifAddr = 32'd0; lsbFlag = 1'b0; lsbOp = 3'd0;
    lsbAddr = 32'd0; lsbDataIn = 32'd0; ramIn = 8'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ifData", ifData, 32'd0);
    check("rst_ifOk", {31'd0, ifOkFlag}, 32'd0);
    check("rst_lsbData", lsbDataOut, 32'd0);
    check("rst_lsbOk", {31'd0, lsbOkFlag}, 32'd0);
    check("rst_ramAddr", ramAddr, 32'd0);
    check("rst_ramWrite", {31'd0, ramWrite}, 32'd0);
    check("rst_ramOut", {24'd0, ramOut}, 32'd0);
    @(posedge clk); #2;
    resetIn = 1'b1;

    // IF word fetch from 0x100
    put(32'h100, 8'h11); put(32'h101, 8'h22); put(32'h102, 8'h33); put(32'h103, 8'h44);
    ifAddr = 32'h100; ifFlag = 1'b1;
    exp_if.push_back(ref_load(32'h100, 4));
    run_window(8, 0, -1, -1, -2, -1, 0);
    for (int i = 1; i <= 4; i++) check("if_ramAddr", rec_addr[i], 32'h100 + 32'(i - 1));
    for (int c = 0; c < 8; c++) check("if_ok_timing", rec_if_ok[c], (c == 6) ? 32'd1 : 32'd0);
    check("if_word_literal", rec_ifdata[6], 32'h4433_2211);

    // LSB byte load from 0x20
    put(32'h20, 8'h80);
    lsbOp = 3'b000; lsbAddr = 32'h20; lsbFlag = 1'b1;
    exp_lsb.push_back({1'b1, ref_load(32'h20, 1)});
    run_window(5, 0, -1, -1, -2, -1, 0);
    for (int c = 0; c < 5; c++) check("lsb_byte_ok_timing", rec_lsb_ok[c], (c == 3) ? 32'd1 : 32'd0);
    check("lsb_byte_literal", rec_lsbdata[3], 32'h0000_0080);

    // LSB half store 0xBEEF to 0x40
    lsbOp = 3'b101; lsbAddr = 32'h40; lsbDataIn = 32'h1234_BEEF; lsbFlag = 1'b1;
    ref_store(32'h40, 2, 32'h1234_BEEF);
    exp_lsb.push_back({1'b0, 32'd0});
    run_window(5, 0, -1, -1, -2, -1, 0);
    check("half_wr1", rec_wr[1], 32'd1);
    check("half_addr1", rec_addr[1], 32'h40);
    check("half_out1", rec_out[1], 32'hEF);
    check("half_wr2", rec_wr[2], 32'd1);
    check("half_addr2", rec_addr[2], 32'h41);
    check("half_out2", rec_out[2], 32'hBE);
    check("half_wr3", rec_wr[3], 32'd0);
    check("half_ok3", rec_lsb_ok[3], 32'd1);

    // Arbitration after reset: IF first, then LSB, then IF's repeated request
    resetIn = 1'b0; @(posedge clk); #2; resetIn = 1'b1;
    ifAddr = 32'h100; ifFlag = 1'b1;
    lsbOp = 3'b000; lsbAddr = 32'h20; lsbFlag = 1'b1;
    exp_if.push_back(ref_load(32'h100, 4));
    exp_lsb.push_back({1'b1, ref_load(32'h20, 1)});
    exp_if.push_back(ref_load(32'h100, 4));
    run_window(19, 0, -1, -1, -2, -1, 1);
    check("arb_lsb_not_first", rec_lsb_ok[3], 32'd0);
    check("arb_if_ok6", rec_if_ok[6], 32'd1);
    check("arb_lsb_addr8", rec_addr[8], 32'h20);
    check("arb_lsb_ok10", rec_lsb_ok[10], 32'd1);
    check("arb_if_ok17", rec_if_ok[17], 32'd1);

    // IO store stalled three cycles
    lsbOp = 3'b100; lsbAddr = 32'h0003_0000; lsbDataIn = 32'h0000_00A5; lsbFlag = 1'b1;
    ref_store(32'h0003_0000, 1, 32'hA5);
    exp_lsb.push_back({1'b0, 32'd0});
    run_window(7, 4, -1, -1, -2, -1, 0);
    for (int c = 1; c <= 3; c++) check("io_stalled", rec_wr[c], 32'd0);
    check("io_wr4", rec_wr[4], 32'd1);
    check("io_addr4", rec_addr[4], 32'h0003_0000);
    check("io_out4", rec_out[4], 32'hA5);
    check("io_ok5", rec_lsb_ok[5], 32'd1);

    // Clear during IF read cycle 3
    ifAddr = 32'h1000; ifFlag = 1'b1;
    run_window(7, 0, 3, -1, -2, -1, 0);
    check("clr_addr3", rec_addr[3], 32'h1002);
    check("clr_idle4", rec_addr[4], 32'd0);
    for (int c = 0; c < 7; c++) check("clr_no_ok", rec_if_ok[c], 32'd0);

    // Clear on the ok cycle suppresses ok
    ifAddr = 32'h1004; ifFlag = 1'b1;
    run_window(8, 0, 6, -1, -2, -1, 0);
    check("clr_ok_addr4", rec_addr[4], 32'h1007);
    check("clr_ok_suppressed", rec_if_ok[6], 32'd0);

    // Clear during word store: all bytes written
    lsbOp = 3'b110; lsbAddr = 32'h50; lsbDataIn = 32'h1122_3344; lsbFlag = 1'b1;
    ref_store(32'h50, 4, 32'h1122_3344);
    exp_lsb.push_back({1'b0, 32'd0});
    run_window(7, 0, 2, -1, -2, -1, 0);
    begin
      logic [31:0] wd;
      wd = 32'h1122_3344;
      for (int i = 0; i < 4; i++) begin
        check("st_clr_wr", rec_wr[i + 1], 32'd1);
        check("st_clr_addr", rec_addr[i + 1], 32'h50 + 32'(i));
        check("st_clr_out", rec_out[i + 1], (wd >> (8 * i)) & 32'hFF);
      end
    end
    check("st_clr_ok5", rec_lsb_ok[5], 32'd1);

    // readyIn low for two cycles mid-read
    ifAddr = 32'h1010; ifFlag = 1'b1;
    exp_if.push_back(ref_load(32'h1010, 4));
    run_window(10, 0, -1, 2, 3, -1, 0);
    check("rdy_addr3", rec_addr[3], 32'h1011);
    check("rdy_addr4", rec_addr[4], 32'h1011);
    check("rdy_addr5", rec_addr[5], 32'h1012);
    check("rdy_no_ok6", rec_if_ok[6], 32'd0);
    check("rdy_ok8", rec_if_ok[8], 32'd1);

    // Reset mid-read
    ifAddr = 32'h1020; ifFlag = 1'b1;
    run_window(6, 0, -1, -1, -2, 3, 0);
    check("rst_mid_addr", rec_addr[4], 32'd0);
    check("rst_mid_wr", rec_wr[4], 32'd0);
    check("rst_mid_ok", rec_if_ok[4], 32'd0);
    check("rst_mid_ifdata", rec_ifdata[4], 32'd0);
    check("rst_mid_lsbdata", rec_lsbdata[4], 32'd0);

    // Random concurrent traffic
    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #2;
          ioBufferFull = ($urandom_range(0, 3) == 0);
        end
        ioBufferFull = 1'b0;
      end
    join_none
    fork
      if_agent(25);
      lsb_agent(40);
    join
    rand_done = 1'b1;
    repeat (4) begin @(posedge clk); #2; end

    check("if_queue_drained", 32'(exp_if.size()), 32'd0);
    check("lsb_queue_drained", 32'(exp_lsb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
